// File: rtl/snn_layer_controller.sv
// Sequencer for one spiking-neural-network layer: walks every neuron per input event,
// fires the layer on a programmable timestep, and optionally runs a leak sweep.
module snn_layer_controller #(
  parameter int NUM_NEURONS   = 16,
  parameter int NUM_INPUTS    = 16,
  parameter int PERIOD_W      = 6,
  parameter int MAX_FIRE_ITER = 4,
  parameter int NEURON_W      = $clog2(NUM_NEURONS),
  parameter int EVENT_W       = $clog2(NUM_INPUTS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        event_valid,
  output logic                        event_ready,
  input  logic [EVENT_W-1:0]          event_addr,
  input  logic [NUM_NEURONS-1:0]      spike,
  input  logic [PERIOD_W-1:0]         period,
  input  logic                        leak_mode,
  output logic                        weight_rd_en,
  output logic                        memb_pot_w_en,
  output logic                        accum_en,
  output logic                        leak_en,
  output logic [EVENT_W+NEURON_W-1:0] mem_addr,
  output logic [NEURON_W-1:0]         neuron_idx,
  output logic                        spike_done,
  output logic                        busy,
  output logic                        fire_overflow
);

  localparam int ITER_W = $clog2(MAX_FIRE_ITER + 1);

  typedef enum logic [2:0] {
    IDLE,
    WEIGHT_LOAD,
    ACCUM,
    SPIKE,
    CLEANUP,
    LEAK
  } state_t;

  state_t                state_q, state_d;
  logic [NEURON_W-1:0]   neuron_idx_q, neuron_idx_d;
  logic [EVENT_W-1:0]    event_q, event_d;
  logic [PERIOD_W-1:0]   timer_q, timer_d;
  logic [ITER_W-1:0]     fire_iter_q, fire_iter_d;
  logic                  fire_overflow_q, fire_overflow_d;
  logic                  weight_rd_en_q, weight_rd_en_d;
  logic                  memb_pot_w_en_q, memb_pot_w_en_d;
  logic                  accum_en_q, accum_en_d;
  logic                  leak_en_q, leak_en_d;
  logic                  spike_done_q, spike_done_d;
  logic                  busy_q, busy_d;

  logic [PERIOD_W-1:0]   period_eff;
  logic                  expired;
  logic                  last_neuron;
  logic                  any_spike;

  // A programmed period of zero behaves as a one-cycle timestep.
  assign period_eff  = (period == '0) ? PERIOD_W'(1) : period;
  assign expired     = (timer_q >= period_eff);
  assign last_neuron = (neuron_idx_q == NEURON_W'(NUM_NEURONS - 1));
  assign any_spike   = (spike != '0);
  assign event_ready = (state_q == IDLE) && !expired && !reset;

  always_comb begin
    state_d         = state_q;
    neuron_idx_d    = neuron_idx_q;
    event_d         = event_q;
    timer_d         = (timer_q == '1) ? timer_q : timer_q + PERIOD_W'(1);
    fire_iter_d     = fire_iter_q;
    fire_overflow_d = fire_overflow_q;

    case (state_q)
      IDLE: begin
        if (expired) begin
          state_d     = SPIKE;
          fire_iter_d = ITER_W'(1);
          timer_d     = '0;
        end else if (event_valid && event_ready) begin
          state_d      = WEIGHT_LOAD;
          event_d      = event_addr;
          neuron_idx_d = '0;
        end
      end
      WEIGHT_LOAD: begin
        neuron_idx_d = neuron_idx_q + NEURON_W'(1);
        if (last_neuron) state_d = ACCUM;
      end
      ACCUM: state_d = IDLE;
      SPIKE: state_d = CLEANUP;
      CLEANUP: begin
        if (any_spike && (fire_iter_q < ITER_W'(MAX_FIRE_ITER))) begin
          state_d     = SPIKE;
          fire_iter_d = fire_iter_q + ITER_W'(1);
        end else begin
          if (any_spike) fire_overflow_d = 1'b1;
          if (leak_mode) begin
            state_d      = LEAK;
            neuron_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LEAK: begin
        neuron_idx_d = neuron_idx_q + NEURON_W'(1);
        if (last_neuron) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered against the next state so they line up with it.
    weight_rd_en_d  = (state_d == WEIGHT_LOAD);
    memb_pot_w_en_d = (state_d == WEIGHT_LOAD);
    accum_en_d      = (state_d == ACCUM);
    spike_done_d    = (state_d == SPIKE);
    leak_en_d       = (state_d == LEAK);
    busy_d          = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      neuron_idx_q    <= '0;
      event_q         <= '0;
      timer_q         <= '0;
      fire_iter_q     <= '0;
      fire_overflow_q <= 1'b0;
      weight_rd_en_q  <= 1'b0;
      memb_pot_w_en_q <= 1'b0;
      accum_en_q      <= 1'b0;
      leak_en_q       <= 1'b0;
      spike_done_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      neuron_idx_q    <= neuron_idx_d;
      event_q         <= event_d;
      timer_q         <= timer_d;
      fire_iter_q     <= fire_iter_d;
      fire_overflow_q <= fire_overflow_d;
      weight_rd_en_q  <= weight_rd_en_d;
      memb_pot_w_en_q <= memb_pot_w_en_d;
      accum_en_q      <= accum_en_d;
      leak_en_q       <= leak_en_d;
      spike_done_q    <= spike_done_d;
      busy_q          <= busy_d;
    end
  end

  assign weight_rd_en  = weight_rd_en_q;
  assign memb_pot_w_en = memb_pot_w_en_q;
  assign accum_en      = accum_en_q;
  assign leak_en       = leak_en_q;
  assign spike_done    = spike_done_q;
  assign busy          = busy_q;
  assign fire_overflow = fire_overflow_q;
  assign neuron_idx    = neuron_idx_q;
  assign mem_addr      = {event_q, neuron_idx_q};

endmodule

// File: tb/tb_snn_layer_controller.sv
// Scoreboard bench for snn_layer_controller: a plan-queue reference model predicts every
// cycle's outputs, and a monitor compares them against the DUT at the falling edge.
module tb_snn_layer_controller;

  localparam int NUM_NEURONS   = 16;
  localparam int NUM_INPUTS    = 16;
  localparam int PERIOD_W      = 6;
  localparam int MAX_FIRE_ITER = 4;
  localparam int NEURON_W      = $clog2(NUM_NEURONS);
  localparam int EVENT_W       = $clog2(NUM_INPUTS);
  localparam int TIMER_MAX     = (1 << PERIOD_W) - 1;

  logic                        clock = 1'b0;
  logic                        reset;
  logic                        event_valid;
  logic                        event_ready;
  logic [EVENT_W-1:0]          event_addr;
  logic [NUM_NEURONS-1:0]      spike;
  logic [PERIOD_W-1:0]         period;
  logic                        leak_mode;
  logic                        weight_rd_en;
  logic                        memb_pot_w_en;
  logic                        accum_en;
  logic                        leak_en;
  logic [EVENT_W+NEURON_W-1:0] mem_addr;
  logic [NEURON_W-1:0]         neuron_idx;
  logic                        spike_done;
  logic                        busy;
  logic                        fire_overflow;

  snn_layer_controller #(
    .NUM_NEURONS(NUM_NEURONS), .NUM_INPUTS(NUM_INPUTS),
    .PERIOD_W(PERIOD_W), .MAX_FIRE_ITER(MAX_FIRE_ITER)
  ) dut (
    .clock(clock), .reset(reset),
    .event_valid(event_valid), .event_ready(event_ready), .event_addr(event_addr),
    .spike(spike), .period(period), .leak_mode(leak_mode),
    .weight_rd_en(weight_rd_en), .memb_pot_w_en(memb_pot_w_en), .accum_en(accum_en),
    .leak_en(leak_en), .mem_addr(mem_addr), .neuron_idx(neuron_idx),
    .spike_done(spike_done), .busy(busy), .fire_overflow(fire_overflow)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                        ready;
    logic                        wr;
    logic                        mw;
    logic                        acc;
    logic                        lk;
    logic                        sd;
    logic                        bsy;
    logic                        ovf;
    logic [NEURON_W-1:0]         idx;
    logic [EVENT_W+NEURON_W-1:0] addr;
  } obs_t;

  // One planned busy cycle: which strobes it shows, and whether it is the settle-check cycle.
  typedef struct {
    bit wr;
    bit acc;
    bit lk;
    bit sd;
    bit decide;
    int idx;
  } step_t;

  obs_t  exp_q[$];
  step_t plan[$];
  int    m_timer;
  int    m_iter;
  bit    m_ovf;
  int    m_event;
  bit    m_hs;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic step_t mk(bit wr, bit acc, bit lk, bit sd, bit decide, int idx);
    step_t s;
    s.wr = wr; s.acc = acc; s.lk = lk; s.sd = sd; s.decide = decide; s.idx = idx;
    return s;
  endfunction

  function automatic void tick_timer();
    if (m_timer < TIMER_MAX) m_timer++;
  endfunction

  function automatic void start_fire_pass();
    plan.push_back(mk(0, 0, 0, 1, 0, 0));
    plan.push_back(mk(0, 0, 0, 0, 1, 0));
  endfunction

  // Predicts outputs for this cycle from the current plan, then advances the plan by one cycle.
  task automatic model_cycle(input bit rst, input bit valid, input int addr,
                             input logic [NUM_NEURONS-1:0] spk, input int per,
                             input bit leak, output obs_t e);
    bit    idle;
    bit    expired;
    step_t cur;
    idle    = (plan.size() == 0);
    expired = (m_timer >= ((per == 0) ? 1 : per));
    cur     = idle ? mk(0, 0, 0, 0, 0, 0) : plan[0];
    e.ready = idle && !expired && !rst;
    e.wr    = cur.wr;
    e.mw    = cur.wr;
    e.acc   = cur.acc;
    e.lk    = cur.lk;
    e.sd    = cur.sd;
    e.bsy   = !idle;
    e.ovf   = m_ovf;
    e.idx   = NEURON_W'(cur.idx);
    e.addr  = (EVENT_W+NEURON_W)'(m_event * NUM_NEURONS + cur.idx);
    m_hs    = 0;
    if (rst) begin
      plan.delete();
      m_timer = 0;
      m_iter  = 0;
      m_ovf   = 0;
      m_event = 0;
    end else if (!idle) begin
      void'(plan.pop_front());
      if (cur.decide) begin
        if (spk != 0 && m_iter < MAX_FIRE_ITER) begin
          m_iter++;
          start_fire_pass();
        end else begin
          if (spk != 0) m_ovf = 1;
          if (leak) for (int i = 0; i < NUM_NEURONS; i++) plan.push_back(mk(0, 0, 1, 0, 0, i));
        end
      end
      tick_timer();
    end else if (expired) begin
      m_iter  = 1;
      m_timer = 0;
      start_fire_pass();
    end else if (valid) begin
      m_hs    = 1;
      m_event = addr;
      for (int i = 0; i < NUM_NEURONS; i++) plan.push_back(mk(1, 0, 0, 0, 0, i));
      plan.push_back(mk(0, 1, 0, 0, 0, 0));
      tick_timer();
    end else begin
      tick_timer();
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit valid, input int addr,
                               input logic [NUM_NEURONS-1:0] spk, input int per, input bit leak);
    obs_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    event_valid = valid;
    event_addr  = EVENT_W'(addr);
    spike       = spk;
    period      = PERIOD_W'(per);
    leak_mode   = leak;
    model_cycle(rst, valid, addr, spk, per, leak, e);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a = {event_ready, weight_rd_en, memb_pot_w_en, accum_en, leak_en, spike_done,
         busy, fire_overflow, neuron_idx, mem_addr};
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("[TB] FAIL outputs @%0t: got rdy=%b wr=%b mw=%b acc=%b lk=%b sd=%b busy=%b ovf=%b idx=%h addr=%h, exp rdy=%b wr=%b mw=%b acc=%b lk=%b sd=%b busy=%b ovf=%b idx=%h addr=%h",
               $time, a.ready, a.wr, a.mw, a.acc, a.lk, a.sd, a.bsy, a.ovf, a.idx, a.addr,
               e.ready, e.wr, e.mw, e.acc, e.lk, e.sd, e.bsy, e.ovf, e.idx, e.addr);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  task automatic idle_cycles(input int n, input int per, input bit leak, input logic [NUM_NEURONS-1:0] spk);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, spk, per, leak);
  endtask

  // Holds an event offered until the model reports its handshake; an expired bound is a failure.
  task automatic offer_event(input int addr, input int per);
    int guard;
    guard = 0;
    do begin
      applyStimulus(0, 1, addr, '0, per, 0);
      guard++;
    end while (!m_hs && guard < 200);
    if (!m_hs) begin
      n_fail++;
      $display("[TB] FAIL handshake addr=%0d: got none within %0d cycles, required one", addr, guard);
    end
  endtask

  initial begin
    int per;
    bit leak;
    reset = 1; event_valid = 0; event_addr = '0; spike = '0; period = '0; leak_mode = 0;
    m_timer = 0; m_iter = 0; m_ovf = 0; m_event = 0; m_hs = 0;
    repeat (2) @(posedge clock);

    $display("[TB] single event sweep");
    idle_cycles(2, 63, 0, '0);
    offer_event(5, 63);
    idle_cycles(20, 63, 0, '0);

    $display("[TB] back-to-back events");
    applyStimulus(1, 1, 3, '0, 63, 0);
    offer_event(3, 63);
    offer_event(9, 63);
    idle_cycles(20, 63, 0, '0);

    $display("[TB] timer priority over pending event");
    applyStimulus(1, 0, 0, '0, 4, 0);
    idle_cycles(3, 4, 0, '0);
    for (int i = 0; i < 30; i++) applyStimulus(0, 1, 11, '0, 4, 0);

    $display("[TB] fire iteration cap");
    applyStimulus(1, 0, 0, '0, 2, 0);
    idle_cycles(20, 2, 0, 16'h0001);
    idle_cycles(20, 63, 0, '0);

    $display("[TB] leak sweep");
    applyStimulus(1, 0, 0, '0, 3, 1);
    idle_cycles(30, 3, 1, '0);

    $display("[TB] reset during weight load");
    applyStimulus(1, 0, 0, '0, 63, 0);
    offer_event(12, 63);
    idle_cycles(7, 63, 0, '0);
    applyStimulus(1, 1, 6, '0, 63, 0);
    offer_event(6, 63);
    idle_cycles(20, 63, 0, '0);

    $display("[TB] randomized traffic");
    per  = 10;
    leak = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_NEURONS-1:0] spk;
      if ($urandom_range(0, 49) == 0) per = $urandom_range(0, 40);
      if ($urandom_range(0, 39) == 0) leak = ~leak;
      spk = ($urandom_range(0, 3) == 0) ? NUM_NEURONS'($urandom) : '0;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
                    int'($urandom_range(0, NUM_INPUTS - 1)), spk, per, leak);
    end

    @(posedge clock);
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
